// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with fill count, almost flags, sticky errors and optional FWFT read.
module fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF       = AF_THRESH[AW:0];
    localparam logic [AW:0] AE       = AE_THRESH[AW:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q, rd_acc, wr_acc;

    always_comb begin
        empty        = count == '0;
        full         = count == FULL_CNT;
        almost_full  = count >= AF;
        almost_empty = count <= AE;
        rd_acc       = rd_en && !empty;
        wr_acc       = wr_en && (!full || rd_acc);
        dout         = FWFT != 0 ? mem[rd_ptr] : dout_q;
        valid        = FWFT != 0 ? !empty : valid_q;
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk)
        if (wr_acc && !rst) mem[wr_ptr] <= din;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout_q <= mem[rd_ptr];
            end
            valid_q   <= rd_acc;
            count     <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
            // a new error in the same cycle as err_clr keeps the flag set
            overflow  <= (wr_en && !wr_acc) || (overflow && !err_clr);
            underflow <= (rd_en && !rd_acc) || (underflow && !err_clr);
        end
    end
endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO: the next-generation buffer for single-clock datapaths. Adds a fill-level count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Full-throughput read-while-full is supported. It sits between a producer and a consumer in one clock domain.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read/pop request
- dout  out  DATA_WIDTH  read data
- valid  out  1  dout holds a valid word (see Operation)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted and rejected
- underflow  out  1  sticky: read attempted and rejected
- err_clr  in  1  clears overflow/underflow on next edge

## Operation
- Storage: DEPTH×DATA_WIDTH array; write and read pointers of AW bits wrap DEPTH-1 → 0. The array is not reset.
- rd_acc = rd_en && !empty. wr_acc = wr_en && (!full || rd_acc). A write when full is accepted only if a read is accepted in the same cycle.
- A read when empty is always rejected, even with a simultaneous write. There is no write-to-read bypass.
- On wr_acc: mem[wr_ptr] ← din; wr_ptr += 1.
- On rd_acc: rd_ptr += 1.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither are accepted.
- empty, full, almost_full and almost_empty decode combinationally from the registered count.
- Standard mode (FWFT=0):
  - On rd_acc, dout ← mem[rd_ptr] at the edge, and valid = 1 for the following cycle only.
  - Otherwise valid = 0 and dout holds its last value.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally, and valid = !empty.
  - rd_en acts as an acknowledge that pops the shown word.
  - The head word appears the cycle after it is written into an empty FIFO.
- Error flags:
  - overflow ← 1 when wr_en && !wr_acc.
  - underflow ← 1 when rd_en && !rd_acc.
  - Both hold until rst, or until err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
- Reset: rst=1 at an edge sets both pointers and count to 0, dout to 0 and valid to 0. It also clears overflow and underflow.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0.
  - Reset overrides any wr_en/rd_en in the same cycle. Mid-operation reset discards all contents.

## Timing
- Write-to-empty-deassert latency: 1 edge. The word written at edge N makes empty=0 after edge N.
- Standard-mode read latency: 1 cycle from the rd_acc edge to dout/valid.
- FWFT read latency: 0. dout is valid whenever valid=1.
- Throughput: one write and one read per cycle, including at full and at wrap-around.
- Flags and count update on the same edge as the pointer change; there is no extra pipeline delay.
- Sticky error flags assert on the edge following the offending request.

## Test plan
- Fill/overflow (DEPTH=16): write 0x01..0x10 on 16 edges → count=16, full=1, almost_full=1 from count=14. 17th write of 0xFF → rejected, overflow=1, contents unchanged.
- Drain/underflow (standard mode): read 16 times → dout = 0x01..0x10 in order, with valid high one cycle after each rd_en. Then empty=1, almost_empty=1 at count≤2. A 17th read → underflow=1 and dout stays 0x10.
- Simultaneous at boundaries:
  - At full, wr_en+rd_en with din=0xAA → both accepted, count stays 16, 0xAA read out 16 pops later.
  - At empty, wr_en+rd_en → write only, count=1, underflow=1.
- Wrap-around: run 40 interleaved write/read cycles with the count oscillating between 3 and 13 → output sequence equals input sequence; count matches a reference model every cycle.
- FWFT mode (FWFT=1): write 0x5A into an empty FIFO → next cycle valid=1, dout=0x5A. Pulse rd_en → valid=0, empty=1.
- Reset/err_clr:
  - Assert rst with count=7 and overflow=1 → next cycle count=0, empty=1, valid=0, dout=0, flags cleared.
  - Assert err_clr alone → flags clear on the next edge.
